// File: rtl/pipeline_ctrl.sv
// Purpose: stage write-enable, bubble and flush sequencer for a five-stage in-order pipeline.
// Latency: outputs decode combinationally from the registered state and this cycle's inputs.
// Backpressure: dmem_ready low freezes the pipe; MAX_WAIT unanswered wait cycles trap in FAULT.
// Optional stall/flush performance counters are compiled in with PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  // Maximum data-memory wait cycles before a fault; legal range 1..255.
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        mem_error,
  output logic [1:0]  ctrl_state
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // One bundle for every stage-control output so each decode is a single constant.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // INIT writes nothing and pushes NOPs into every stage register.
  localparam ctrl_t CTRL_INIT   = ctrl_t'(6'b000_111);
  // Freeze: everything upstream of MEM holds, WB receives a NOP.
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000_001);
  // Stall: PC and IF/ID hold, a bubble enters EX, older work drains through EX/MEM.
  localparam ctrl_t CTRL_STALL  = ctrl_t'(6'b001_010);
  // Taken branch: redirect PC and squash the wrong-path fetch in IF/ID.
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(6'b111_100);
  localparam ctrl_t CTRL_NORMAL = ctrl_t'(6'b111_000);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  ctrl_t      ctrl;

  // Unfrozen priority: stall > missing fetch > branch > normal. A branch seen
  // with a stall is not lost: IF/ID holds, so the branch re-resolves next cycle.
  function automatic ctrl_t run_decode(input logic stall_req, input logic fetch_ok,
                                       input logic branch);
    ctrl_t c;
    if (stall_req || !fetch_ok) begin
      c = CTRL_STALL;
    end else if (branch) begin
      c = CTRL_BRANCH;
    end else begin
      c = CTRL_NORMAL;
    end
    return c;
  endfunction

  // Next state, wait counter and output decode. The MEM_WAIT cycle that sees
  // dmem_ready already uses the unfrozen decode so the release costs no cycle.
  always_comb begin
    ctrl         = CTRL_INIT;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_INIT: begin
        ctrl         = CTRL_INIT;
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          ctrl         = CTRL_FREEZE;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          ctrl = run_decode(hazard_stall, imem_ready, branch_taken);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl         = run_decode(hazard_stall, imem_ready, branch_taken);
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt >= MAX_WAIT_C) begin
            state_nxt = ST_FAULT;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        // Only reset leaves FAULT; the pipe stays frozen meanwhile.
        ctrl = CTRL_FREEZE;
      end
      default: begin
        ctrl      = CTRL_INIT;
        state_nxt = ST_INIT;
      end
    endcase
  end

  // State and wait counter; reset forces INIT, which also decodes the reset outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign exmem_write  = ctrl.exmem_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  // FAULT is only left through reset, so the error flag is sticky by construction.
  assign mem_error    = (state == ST_FAULT);
  assign ctrl_state   = state;

`ifdef PIPELINE_CTRL_PERF_EN
  logic active;
  assign active = (state == ST_RUN) || (state == ST_MEM_WAIT);

  // Saturating counts of PC-hold cycles while active and of IF/ID flushes in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (active && !ctrl.pc_write && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if ((state == ST_RUN) && ctrl.ifid_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MAX_WAIT = 4).
// Expected output vectors are queued as stimulus is applied and popped when sampled.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_write, ifid_write, exmem_write;
  logic        ifid_flush, idex_bubble, memwb_bubble;
  logic        mem_error;
  logic [1:0]  ctrl_state;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];

  // Observed vector: {pc_write, ifid_write, exmem_write, ifid_flush, idex_bubble,
  //                   memwb_bubble, mem_error, ctrl_state}
  localparam logic [8:0] E_INIT    = 9'b000_111_0_00;
  localparam logic [8:0] E_NORM    = 9'b111_000_0_01;
  localparam logic [8:0] E_STALL   = 9'b001_010_0_01;
  localparam logic [8:0] E_BR      = 9'b111_100_0_01;
  localparam logic [8:0] E_FRZ_R   = 9'b000_001_0_01;
  localparam logic [8:0] E_FRZ_W   = 9'b000_001_0_10;
  localparam logic [8:0] E_NORM_W  = 9'b111_000_0_10;
  localparam logic [8:0] E_STALL_W = 9'b001_010_0_10;
  localparam logic [8:0] E_BR_W    = 9'b111_100_0_10;
  localparam logic [8:0] E_FAULT   = 9'b000_001_1_11;

  pipeline_ctrl #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .memwb_bubble (memwb_bubble),
    .mem_error    (mem_error),
    .ctrl_state   (ctrl_state)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {pc_write, ifid_write, exmem_write, ifid_flush, idex_bubble,
            memwb_bubble, mem_error, ctrl_state};
  endfunction

  // Apply {hazard, branch, imem_ready, dmem_req, dmem_ready} after a falling
  // edge and wait to the sample point, well clear of the next rising edge.
  task automatic step_drive(input logic [4:0] v);
    @(negedge clk);
    {hazard_stall, branch_taken, imem_ready, dmem_req, dmem_ready} = v;
    #2;
  endtask

  // Async reset takes effect at once; after release exactly one INIT cycle precedes RUN.
  task automatic test_reset(input string tag);
    logic [8:0] g, e;
    rst_n = 1'b0;
    exp_q.push_back(E_INIT);
    #1;
    g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_%s_async: got %b expected %b", tag, g, e); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    {hazard_stall, branch_taken, imem_ready, dmem_req, dmem_ready} = 5'b00100;
    exp_q.push_back(E_INIT);
    #2;
    g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_%s_init_cycle: got %b expected %b", tag, g, e); end
    step_drive(5'b00100);
    exp_q.push_back(E_NORM);
    g = obs(); e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_%s_run: got %b expected %b", tag, g, e); end
  endtask

  task automatic test_hazard();
    logic [4:0] stim [7];
    logic [8:0] expv [7];
    logic [8:0] g, e;
    stim = '{5'b00100, 5'b10100, 5'b00100, 5'b00000, 5'b10000, 5'b00111, 5'b00100};
    expv = '{E_NORM,   E_STALL,  E_NORM,   E_STALL,  E_STALL,  E_NORM,   E_NORM};
    for (int i = 0; i < 7; i++) begin
      step_drive(stim[i]);
      exp_q.push_back(expv[i]);
      g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL hazard step %0d: got %b expected %b", i, g, e); end
    end
  endtask

  task automatic test_branch();
    logic [4:0] stim [8];
    logic [8:0] expv [8];
    logic [8:0] g, e;
    stim = '{5'b11100, 5'b01100, 5'b00100, 5'b01000, 5'b01100, 5'b01110, 5'b01101, 5'b00100};
    expv = '{E_STALL,  E_BR,     E_NORM,   E_STALL,  E_BR,     E_FRZ_R,  E_BR_W,   E_NORM};
    for (int i = 0; i < 8; i++) begin
      step_drive(stim[i]);
      exp_q.push_back(expv[i]);
      g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL branch step %0d: got %b expected %b", i, g, e); end
    end
  endtask

  // Three cycles without dmem_ready freeze the pipe; the fourth releases in place.
  task automatic test_mem_wait();
    logic [4:0] stim [9];
    logic [8:0] expv [9];
    logic [8:0] g, e;
    stim = '{5'b00110, 5'b00110, 5'b00110, 5'b00111, 5'b00100,
             5'b00110, 5'b10010, 5'b10011, 5'b00100};
    expv = '{E_FRZ_R,  E_FRZ_W,  E_FRZ_W,  E_NORM_W, E_NORM,
             E_FRZ_R,  E_FRZ_W,  E_STALL_W, E_NORM};
    for (int i = 0; i < 9; i++) begin
      step_drive(stim[i]);
      exp_q.push_back(expv[i]);
      g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mem_wait step %0d: got %b expected %b", i, g, e); end
    end
  endtask

  // Ready arriving on the last allowed wait cycle still releases; one more wait faults.
  task automatic test_fault();
    logic [4:0] stim [16];
    logic [8:0] expv [16];
    logic [8:0] g, e;
    stim = '{5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b00111, 5'b00100,
             5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b00110,
             5'b00110, 5'b00111, 5'b00100, 5'b11101, 5'b00000};
    expv = '{E_FRZ_R,  E_FRZ_W,  E_FRZ_W,  E_FRZ_W,  E_NORM_W, E_NORM,
             E_FRZ_R,  E_FRZ_W,  E_FRZ_W,  E_FRZ_W,  E_FRZ_W,
             E_FAULT,  E_FAULT,  E_FAULT,  E_FAULT,  E_FAULT};
    for (int i = 0; i < 16; i++) begin
      step_drive(stim[i]);
      exp_q.push_back(expv[i]);
      g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL fault step %0d: got %b expected %b", i, g, e); end
    end
  endtask

  // Reach MEM_WAIT so the following reset aborts a live wait.
  task automatic test_enter_wait();
    logic [4:0] stim [3];
    logic [8:0] expv [3];
    logic [8:0] g, e;
    stim = '{5'b00100, 5'b00110, 5'b00110};
    expv = '{E_NORM,   E_FRZ_R,  E_FRZ_W};
    for (int i = 0; i < 3; i++) begin
      step_drive(stim[i]);
      exp_q.push_back(expv[i]);
      g = obs(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL enter_wait step %0d: got %b expected %b", i, g, e); end
    end
  endtask

`ifdef PIPELINE_CTRL_PERF_EN
  task automatic test_perf();
    logic [31:0] g, e;
    logic [31:0] pq[$];
    pq.push_back({16'd0, 16'd0});
    g = {stall_cycles, flush_count}; e = pq.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL perf_clear: got %h expected %h", g, e); end
    step_drive(5'b10100);
    step_drive(5'b10100);
    step_drive(5'b01100);
    step_drive(5'b00100);
    pq.push_back({16'd2, 16'd1});
    g = {stall_cycles, flush_count}; e = pq.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL perf_counts: got %h expected %h", g, e); end
    step_drive(5'b10100);
    repeat (70000) @(posedge clk);
    pq.push_back({16'hFFFF, 16'd1});
    @(negedge clk); #2;
    g = {stall_cycles, flush_count}; e = pq.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL perf_saturate: got %h expected %h", g, e); end
  endtask
`endif

  initial begin
    test_reset("first");
    test_hazard();
    test_branch();
    test_mem_wait();
    test_fault();
    test_reset("from_fault");
    test_enter_wait();
    test_reset("mid_wait");
`ifdef PIPELINE_CTRL_PERF_EN
    test_reset("perf");
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
